fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the combinational instruction memory. It owns the program counter and drives the memory address. It captures the returned instruction into the IF/ID pipeline register and handles stall, branch/jump redirect, and halt. The decode/control stage consumes its IF/ID outputs.

Parameters:
SIZE_IM, 128, instruction-memory depth in 32-bit words; valid byte addresses are 0 to 4*SIZE_IM-4.
RESET_PC, 32'h00000000, PC value loaded on reset.
HALT_WORD, 32'hFC000000, halt encoding (opcode 6'b111111), also returned for out-of-range fetches.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = in reset).
i_Instruction  input  32  instruction word returned combinationally by instruction memory for o_PC.
i_Stall  input  1  hazard stall from decode; hold PC and IF/ID.
i_Redirect  input  1  taken branch/jump resolved downstream; flush and reload PC.
i_Target  input  32  redirect byte address, sampled when i_Redirect=1.
o_PC  output  32  current fetch address, driven to instruction memory address input.
o_IfId_Instr  output  32  registered instruction for decode.
o_IfId_PC4  output  32  registered PC+4 of that instruction.
o_IfId_Valid  output  1  IF/ID holds a real instruction (0 = bubble).
o_Halted  output  1  sticky; fetch has stopped on a halt word.
o_Fetch_Count  output  32  count of instructions accepted into IF/ID.

Behaviour:
- Reset (reset=0, asynchronous): o_PC=RESET_PC, o_IfId_Instr=0, o_IfId_PC4=0, o_IfId_Valid=0, o_Halted=0, o_Fetch_Count=0. Reset release takes effect at the first rising edge with reset=1.
- Fetched word f: if o_PC >= 4*SIZE_IM, f=HALT_WORD; otherwise f=i_Instruction.
- Per-edge priority, highest first: redirect, then halted, then stall, then advance.
- Redirect (i_Redirect=1): PC <= {i_Target[31:2],2'b00} (low bits forced to 0). IF/ID becomes a bubble (Instr=0, PC4=0, Valid=0). Counter unchanged.
  - Redirect overrides i_Stall.
  - Redirect overrides a halt word fetched in the same cycle; o_Halted stays 0.
- Halted (o_Halted=1): PC, counter and o_Halted hold. IF/ID is a bubble (Valid=0). i_Redirect and i_Stall are ignored. Only reset exits.
- Stall (i_Stall=1, no redirect, not halted): PC, IF/ID and counter all hold their values.
- Advance: IF/ID <= {f, o_PC+4, Valid=1}; counter +1.
  - If f[31:26]==6'b111111: PC holds and o_Halted <= 1. The halt word still enters IF/ID once with Valid=1, so decode sees it.
  - Otherwise PC <= o_PC+4.
- Latency: the instruction at address A appears on o_IfId_Instr one edge after o_PC=A, absent stall or redirect.
- Arithmetic: PC+4 wraps modulo 2^32. o_Fetch_Count wraps modulo 2^32.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package cpu_pkg holds:
  - OPC_HALT = 6'b111111
  - HALT_WORD
  - NOP_WORD = 32'h00000000
  - IF/ID field widths
- One sub-module: pc_reg, the PC register with load-enable and async active-low reset.
- fetch_unit instantiates pc_reg and implements the IF/ID register, halt logic and counter.

Test Plan:
1. Reset and sequential fetch: release reset with the memory model returning words W0..W3 at 0x0..0xC. Required: o_PC steps 0, 4, 8, C; IF/ID shows W0/PC4=4 one edge after o_PC=0; o_Fetch_Count=4 after four advances.
2. Stall: hold i_Stall=1 for 3 cycles while o_PC=8. Required: o_PC stays 8, IF/ID unchanged, counter unchanged; fetch resumes at 8 on release.
3. Redirect: at o_PC=0x10 pulse i_Redirect with i_Target=0x42, together with i_Stall=1. Required: next o_PC=0x40, IF/ID Valid=0, Instr=0; the following edge captures the word at 0x40.
4. Halt: memory returns 0xFC000000 at 0x14. Required: IF/ID=0xFC000000 with Valid=1 once, then Valid=0; o_Halted=1; o_PC frozen at 0x14; a later i_Redirect to 0x0 has no effect.
5. Redirect over halt: in the cycle the halt word is fetched, assert i_Redirect to 0x20. Required: o_Halted=0, o_PC=0x20, bubble in IF/ID.
6. Out-of-range and reset mid-run: jump to 0x200 with SIZE_IM=128. Required: HALT_WORD captured and o_Halted=1. Then drive reset=0 asynchronously between edges. Required: all outputs return to reset values immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the IF/ID pipeline register layout.
// Imported by the fetch stage and anything that consumes IF/ID.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int OPC_W   = 6;

  localparam logic [OPC_W-1:0]   OPC_HALT  = 6'b111111;
  localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFC000000;
  localparam logic [INSTR_W-1:0] NOP_WORD  = 32'h00000000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc4;
    logic               vld;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_WORD, pc4: '0, vld: 1'b0};

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: OPC_W] == OPC_HALT;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: loads d when load=1, otherwise holds; async active-low reset.
// One-edge latency from d to q; no flow control of its own, the caller gates load.
module pc_reg #(
  parameter int           W         = 32,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, captures the fetched word into IF/ID one edge after o_PC.
// i_Stall holds PC and IF/ID; i_Redirect flushes IF/ID and reloads PC; a halt word freezes fetch until reset.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          SIZE_IM   = 128,
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] HALT_WORD = cpu_pkg::HALT_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_Instruction,
  input  logic        i_Stall,
  input  logic        i_Redirect,
  input  logic [31:0] i_Target,
  output logic [31:0] o_PC,
  output logic [31:0] o_IfId_Instr,
  output logic [31:0] o_IfId_PC4,
  output logic        o_IfId_Valid,
  output logic        o_Halted,
  output logic [31:0] o_Fetch_Count
);

  // One bit wider than the PC so the byte limit cannot overflow for any depth.
  localparam logic [PC_W:0] IM_LIMIT = 33'(SIZE_IM) << 2;

  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_plus4;
  logic [PC_W-1:0]    pc_next;
  logic               pc_load;
  logic               in_range;
  logic [INSTR_W-1:0] fetched;
  logic               fetched_halt;
  logic               advance;
  ifid_t              ifid;
  logic               halted;
  logic [31:0]        fetch_count;

  assign pc_plus4     = pc + 32'd4;
  assign in_range     = {1'b0, pc} < IM_LIMIT;
  assign fetched      = in_range ? i_Instruction : HALT_WORD;
  assign fetched_halt = is_halt(fetched);
  assign advance      = !halted && !i_Redirect && !i_Stall;

  // Once halted, redirect is ignored; before that it beats a same-cycle halt fetch.
  always_comb begin
    pc_load = 1'b0;
    pc_next = pc;
    if (!halted) begin
      if (i_Redirect) begin
        pc_load = 1'b1;
        pc_next = {i_Target[PC_W-1:2], 2'b00};
      end else if (!i_Stall && !fetched_halt) begin
        pc_load = 1'b1;
        pc_next = pc_plus4;
      end
    end
  end

  pc_reg #(
    .W        (PC_W),
    .RESET_VAL(RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .reset(reset),
    .load (pc_load),
    .d    (pc_next),
    .q    (pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid        <= IFID_BUBBLE;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else if (halted || i_Redirect) begin
      ifid <= IFID_BUBBLE;
    end else if (advance) begin
      ifid        <= '{instr: fetched, pc4: pc_plus4, vld: 1'b1};
      fetch_count <= fetch_count + 32'd1;
      if (fetched_halt) begin
        halted <= 1'b1;
      end
    end
  end

  assign o_PC          = pc;
  assign o_IfId_Instr  = ifid.instr;
  assign o_IfId_PC4    = ifid.pc4;
  assign o_IfId_Valid  = ifid.vld;
  assign o_Halted      = halted;
  assign o_Fetch_Count = fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table for the corner cases, then random stimulus
// against a behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam int          SIZE_IM = 128;
  localparam logic [31:0] HALT    = 32'hFC000000;

  logic        clk;
  logic        reset;
  logic [31:0] i_instruction;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_target;
  logic [31:0] o_pc;
  logic [31:0] o_ifid_instr;
  logic [31:0] o_ifid_pc4;
  logic        o_ifid_valid;
  logic        o_halted;
  logic [31:0] o_fetch_count;

  logic [31:0] mem [SIZE_IM];

  int vectors;
  int miscompares;

  fetch_unit #(.SIZE_IM(SIZE_IM)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_Instruction(i_instruction),
    .i_Stall      (i_stall),
    .i_Redirect   (i_redirect),
    .i_Target     (i_target),
    .o_PC         (o_pc),
    .o_IfId_Instr (o_ifid_instr),
    .o_IfId_PC4   (o_ifid_pc4),
    .o_IfId_Valid (o_ifid_valid),
    .o_Halted     (o_halted),
    .o_Fetch_Count(o_fetch_count)
  );

  // Out-of-range reads return a non-halt pattern so the DUT must substitute HALT_WORD itself.
  assign i_instruction = (o_pc < 32'(4 * SIZE_IM)) ? mem[o_pc[8:2]] : {16'h0BAD, o_pc[15:0]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          kind;  // 0 = one clock edge, 1 = async reset pulse between edges
    bit          stall;
    bit          redir;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    bit          e_vld;
    bit          e_halt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  bit          m_vld, m_halted;

  function automatic vec_t mk(int kind, bit s, bit r, logic [31:0] t, logic [31:0] pc,
                              logic [31:0] ins, logic [31:0] p4, bit v, bit h, logic [31:0] c);
    vec_t x;
    x.kind = kind; x.stall = s; x.redir = r; x.tgt = t;
    x.e_pc = pc; x.e_instr = ins; x.e_pc4 = p4; x.e_vld = v; x.e_halt = h; x.e_cnt = c;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] p4, input bit v, input bit h, input logic [31:0] c);
    check({tag, ".pc"},    o_pc,                  pc);
    check({tag, ".instr"}, o_ifid_instr,          ins);
    check({tag, ".pc4"},   o_ifid_pc4,            p4);
    check({tag, ".valid"}, {31'd0, o_ifid_valid}, {31'd0, v});
    check({tag, ".halt"},  {31'd0, o_halted},     {31'd0, h});
    check({tag, ".count"}, o_fetch_count,         c);
  endtask

  // Called just after an edge; outputs are checked while reset is held low.
  task automatic async_reset(input string tag);
    #1 reset = 1'b0;
    #1 check_all(tag, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 reset = 1'b1;
  endtask

  task automatic do_cycle(input bit s, input bit r, input logic [31:0] t);
    i_stall = s; i_redirect = r; i_target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_vld = 0; m_halted = 0; m_cnt = 32'h0;
  endtask

  // Fetch rules applied to the pre-edge state: a halted stage ignores everything.
  task automatic model_step(input bit s, input bit r, input logic [31:0] t);
    logic [31:0] f;
    f = (m_pc >= 32'(4 * SIZE_IM)) ? HALT : mem[m_pc / 4];
    if (m_halted || r) begin
      if (!m_halted) m_pc = t & 32'hFFFF_FFFC;
      m_instr = 32'h0; m_pc4 = 32'h0; m_vld = 0;
    end else if (!s) begin
      m_instr = f; m_pc4 = m_pc + 32'd4; m_vld = 1; m_cnt = m_cnt + 32'd1;
      if (f[31:26] == 6'h3F) m_halted = 1;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    i_stall = 1'b0; i_redirect = 1'b0; i_target = 32'h0;
    for (int i = 0; i < SIZE_IM; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[5] = HALT;

    // Directed table: sequential fetch, stall, redirect, halt, redirect-over-halt, out-of-range.
    tbl.push_back(mk(0, 0, 0, 0,      32'h04,  32'h10000000, 32'h04,  1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,      32'h08,  32'h10000001, 32'h08,  1, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0,      32'h08,  32'h10000001, 32'h08,  1, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0,      32'h08,  32'h10000001, 32'h08,  1, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0,      32'h08,  32'h10000001, 32'h08,  1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0,      32'h0C,  32'h10000002, 32'h0C,  1, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0,      32'h10,  32'h10000003, 32'h10,  1, 0, 4));
    tbl.push_back(mk(0, 1, 1, 32'h42, 32'h40,  32'h0,        32'h0,   0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0,      32'h44,  32'h10000010, 32'h44,  1, 0, 5));
    tbl.push_back(mk(0, 0, 1, 32'h10, 32'h10,  32'h0,        32'h0,   0, 0, 5));
    tbl.push_back(mk(0, 0, 0, 0,      32'h14,  32'h10000004, 32'h14,  1, 0, 6));
    tbl.push_back(mk(0, 0, 0, 0,      32'h14,  HALT,         32'h18,  1, 1, 7));
    tbl.push_back(mk(0, 0, 0, 0,      32'h14,  32'h0,        32'h0,   0, 1, 7));
    tbl.push_back(mk(0, 0, 1, 32'h0,  32'h14,  32'h0,        32'h0,   0, 1, 7));
    tbl.push_back(mk(0, 1, 0, 0,      32'h14,  32'h0,        32'h0,   0, 1, 7));
    tbl.push_back(mk(1, 0, 0, 0,      32'h0,   32'h0,        32'h0,   0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h14, 32'h14,  32'h0,        32'h0,   0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h20, 32'h20,  32'h0,        32'h0,   0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,      32'h24,  32'h10000008, 32'h24,  1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 32'h200,32'h200, 32'h0,        32'h0,   0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,      32'h200, HALT,         32'h204, 1, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0,      32'h200, 32'h0,        32'h0,   0, 1, 2));
    tbl.push_back(mk(1, 0, 0, 0,      32'h0,   32'h0,        32'h0,   0, 0, 0));

    @(posedge clk);
    #1 check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 reset = 1'b1;

    foreach (tbl[i]) begin
      if (tbl[i].kind == 1) begin
        async_reset($sformatf("t%0d.rst", i));
      end else begin
        do_cycle(tbl[i].stall, tbl[i].redir, tbl[i].tgt);
        check_all($sformatf("t%0d", i), tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_pc4,
                  tbl[i].e_vld, tbl[i].e_halt, tbl[i].e_cnt);
      end
    end

    // Random program with occasional halt-opcode words, random stalls, redirects and resets.
    for (int i = 0; i < SIZE_IM; i++) begin
      logic [31:0] w;
      w = $urandom();
      if ($urandom_range(0, 99) < 4) w[31:26] = 6'h3F;
      else if (w[31:26] == 6'h3F) w[31] = 1'b0;
      mem[i] = w;
    end
    async_reset("rnd.rst0");
    model_reset();
    for (int n = 0; n < 2500; n++) begin
      bit          s, r;
      logic [31:0] t;
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        async_reset($sformatf("rnd%0d.rst", n));
        model_reset();
      end
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 32'h300)) : 32'($urandom_range(0, 4 * SIZE_IM - 1));
      model_step(s, r, t);
      do_cycle(s, r, t);
      check_all($sformatf("rnd%0d", n), m_pc, m_instr, m_pc4, m_vld, m_halted, m_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
